// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and opcode table for the ALU operand loader / result capture stage.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [4:0] OP_AND = 5'h0;
  localparam logic [4:0] OP_OR  = 5'h1;
  localparam logic [4:0] OP_ADD = 5'h2;
  localparam logic [4:0] OP_INC = 5'h3;
  localparam logic [4:0] OP_DEC = 5'h4;
  localparam logic [4:0] OP_NOT = 5'h5;
  localparam logic [4:0] OP_SUB = 5'h6;
  localparam logic [4:0] OP_XOR = 5'h7;
  localparam logic [4:0] OP_SHL = 5'h8;
  localparam logic [4:0] OP_SHR = 5'h9;
  localparam logic [4:0] OP_MAX = 5'h9;

  // Single-operand ops only accept flag values 0 and 1.
  function automatic logic op_valid(input logic [4:0] op, input logic [1:0] flag);
    logic v;
    if (op > OP_MAX) begin
      v = 1'b0;
    end else if (((op == OP_INC) || (op == OP_DEC) || (op == OP_NOT) ||
                  (op == OP_SHL) || (op == OP_SHR)) && (flag > 2'd1)) begin
      v = 1'b0;
    end else begin
      v = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// User bus, ALU drive/return and status signals of the operand loader.
interface alu_seq_ctrl_if #(
  parameter int ANCHO = 4,
  parameter int CNT_W = 8
);
  logic [ANCHO-1:0] data_in;
  logic [4:0]       op_in;
  logic [1:0]       flag_in;
  logic             load;
  logic             abort;
  logic [ANCHO-1:0] alu_a;
  logic [ANCHO-1:0] alu_b;
  logic [4:0]       alu_control;
  logic [1:0]       alu_flag;
  logic [ANCHO-1:0] alu_result;
  logic [1:0]       alu_c;
  logic [1:0]       alu_z;
  logic [ANCHO-1:0] result_q;
  logic [1:0]       c_q;
  logic [1:0]       z_q;
  logic             result_valid;
  logic             err;
  logic             busy;
  logic [2:0]       stage;
  logic [CNT_W-1:0] op_count;

  modport master (
    output data_in, op_in, flag_in, load, abort, alu_result, alu_c, alu_z,
    input  alu_a, alu_b, alu_control, alu_flag, result_q, c_q, z_q,
           result_valid, err, busy, stage, op_count
  );

  modport slave (
    input  data_in, op_in, flag_in, load, abort, alu_result, alu_c, alu_z,
    output alu_a, alu_b, alu_control, alu_flag, result_q, c_q, z_q,
           result_valid, err, busy, stage, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Loads A, B, then opcode/flag from one shared bus, drives the ALU and
// captures its result one settle cycle later.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int ANCHO = 4,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seq_ctrl_if.slave bus
);

  state_t           state_r, state_nx_s;
  logic [ANCHO-1:0] alu_a_r, alu_a_nx_s, alu_b_r, alu_b_nx_s;
  logic [4:0]       ctrl_r, ctrl_nx_s;
  logic [1:0]       flag_r, flag_nx_s;
  logic [ANCHO-1:0] res_r, res_nx_s;
  logic [1:0]       c_r, c_nx_s, z_r, z_nx_s;
  logic             rv_r, rv_nx_s, err_r, err_nx_s, busy_r, busy_nx_s;
  logic [2:0]       stage_r, stage_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;

  function automatic logic [2:0] stage_of(input state_t s);
    logic [2:0] v;
    case (s)
      WAIT_A:  v = 3'b001;
      WAIT_B:  v = 3'b010;
      WAIT_OP: v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Next-state and next register values; abort overrides any load.
  always_comb begin
    state_nx_s = state_r;
    alu_a_nx_s = alu_a_r;
    alu_b_nx_s = alu_b_r;
    ctrl_nx_s  = ctrl_r;
    flag_nx_s  = flag_r;
    res_nx_s   = res_r;
    c_nx_s     = c_r;
    z_nx_s     = z_r;
    rv_nx_s    = rv_r;
    err_nx_s   = err_r;
    cnt_nx_s   = cnt_r;
    if (bus.abort) begin
      state_nx_s = WAIT_A;
      rv_nx_s    = 1'b0;
      err_nx_s   = 1'b0;
    end else begin
      case (state_r)
        WAIT_A: begin
          if (bus.load) begin
            alu_a_nx_s = bus.data_in;
            state_nx_s = WAIT_B;
          end else begin
            state_nx_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (bus.load) begin
            alu_b_nx_s = bus.data_in;
            state_nx_s = WAIT_OP;
          end else begin
            state_nx_s = WAIT_B;
          end
        end
        WAIT_OP: begin
          if (bus.load) begin
            ctrl_nx_s = bus.op_in;
            flag_nx_s = bus.flag_in;
            if (op_valid(bus.op_in, bus.flag_in)) begin
              state_nx_s = EXEC;
              err_nx_s   = 1'b0;
            end else begin
              state_nx_s = DONE;
              err_nx_s   = 1'b1;
              res_nx_s   = {ANCHO{1'b0}};
              c_nx_s     = 2'b00;
              z_nx_s     = 2'b00;
              rv_nx_s    = 1'b1;
            end
          end else begin
            state_nx_s = WAIT_OP;
          end
        end
        EXEC: begin
          res_nx_s   = bus.alu_result;
          c_nx_s     = bus.alu_c;
          z_nx_s     = bus.alu_z;
          rv_nx_s    = 1'b1;
          cnt_nx_s   = cnt_r + CNT_W'(1);
          state_nx_s = DONE;
        end
        DONE: begin
          // Fast re-entry: the strobe that leaves DONE already carries operand A.
          if (bus.load) begin
            alu_a_nx_s = bus.data_in;
            rv_nx_s    = 1'b0;
            err_nx_s   = 1'b0;
            state_nx_s = WAIT_B;
          end else begin
            state_nx_s = DONE;
          end
        end
        default: begin
          state_nx_s = WAIT_A;
          rv_nx_s    = 1'b0;
          err_nx_s   = 1'b0;
        end
      endcase
    end
    busy_nx_s  = (state_nx_s == EXEC);
    stage_nx_s = stage_of(state_nx_s);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_A;
      alu_a_r <= {ANCHO{1'b0}};
      alu_b_r <= {ANCHO{1'b0}};
      ctrl_r  <= 5'd0;
      flag_r  <= 2'd0;
      res_r   <= {ANCHO{1'b0}};
      c_r     <= 2'd0;
      z_r     <= 2'd0;
      rv_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      stage_r <= 3'b001;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      alu_a_r <= alu_a_nx_s;
      alu_b_r <= alu_b_nx_s;
      ctrl_r  <= ctrl_nx_s;
      flag_r  <= flag_nx_s;
      res_r   <= res_nx_s;
      c_r     <= c_nx_s;
      z_r     <= z_nx_s;
      rv_r    <= rv_nx_s;
      err_r   <= err_nx_s;
      busy_r  <= busy_nx_s;
      stage_r <= stage_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  assign bus.alu_a        = alu_a_r;
  assign bus.alu_b        = alu_b_r;
  assign bus.alu_control  = ctrl_r;
  assign bus.alu_flag     = flag_r;
  assign bus.result_q     = res_r;
  assign bus.c_q          = c_r;
  assign bus.z_q          = z_r;
  assign bus.result_valid = rv_r;
  assign bus.err          = err_r;
  assign bus.busy         = busy_r;
  assign bus.stage        = stage_r;
  assign bus.op_count     = cnt_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU attached.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_ctrl_if #(.ANCHO(4), .CNT_W(8)) bus ();

  alu_seq_ctrl #(.ANCHO(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the ALU: 5-bit raw result, bit 4 is carry/borrow.
  logic [4:0] r5;
  always_comb begin
    r5 = 5'd0;
    case (bus.alu_control)
      5'h0: r5 = {1'b0, bus.alu_a & bus.alu_b};
      5'h1: r5 = {1'b0, bus.alu_a | bus.alu_b};
      5'h2: r5 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      5'h3: r5 = {1'b0, bus.alu_a} + 5'd1;
      5'h4: r5 = {1'b0, bus.alu_a} - 5'd1;
      5'h5: r5 = {1'b0, ~bus.alu_a};
      5'h6: r5 = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      5'h7: r5 = {1'b0, bus.alu_a ^ bus.alu_b};
      5'h8: r5 = {bus.alu_a, 1'b0};
      5'h9: r5 = {2'b00, bus.alu_a[3:1]};
      default: r5 = 5'd0;
    endcase
    bus.alu_result = r5[3:0];
    bus.alu_c      = {1'b0, r5[4]};
    bus.alu_z      = (r5[3:0] == 4'd0) ? 2'b01 : 2'b00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_load(input logic [3:0] d);
    @(negedge clk);
    bus.data_in = d;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic load_op(input logic [4:0] op, input logic [1:0] fl);
    @(negedge clk);
    bus.op_in   = op;
    bus.flag_in = fl;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic load_three(input logic [3:0] a, input logic [3:0] b,
                            input logic [4:0] op, input logic [1:0] fl);
    drive_load(a);
    drive_load(b);
    load_op(op, fl);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.data_in = 4'h0;
    bus.op_in   = 5'h0;
    bus.flag_in = 2'b00;
    bus.load    = 1'b0;
    bus.abort   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stage", 32'(bus.stage), 32'h1);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_valid", 32'(bus.result_valid), 32'h0);
    chk("rst_count", 32'(bus.op_count), 32'h0);
    rst = 1'b0;

    // C AND A = 8
    load_three(4'hC, 4'hA, 5'h0, 2'b00);
    chk("and_busy", 32'(bus.busy), 32'h1);
    chk("and_valid_early", 32'(bus.result_valid), 32'h0);
    chk("and_stage_exec", 32'(bus.stage), 32'h0);
    @(negedge clk);
    chk("and_valid", 32'(bus.result_valid), 32'h1);
    chk("and_result", 32'(bus.result_q), 32'h8);
    chk("and_z", 32'(bus.z_q), 32'h0);
    chk("and_count", 32'(bus.op_count), 32'h1);
    chk("and_busy_off", 32'(bus.busy), 32'h0);

    // 9 + 8 wraps to 1 with carry, entered from DONE
    drive_load(4'h9);
    chk("reentry_valid", 32'(bus.result_valid), 32'h0);
    chk("reentry_stage", 32'(bus.stage), 32'h2);
    drive_load(4'h8);
    load_op(5'h2, 2'b00);
    @(negedge clk);
    chk("add_result", 32'(bus.result_q), 32'h1);
    chk("add_c", 32'(bus.c_q), 32'h1);
    chk("add_z", 32'(bus.z_q), 32'h0);
    chk("add_count", 32'(bus.op_count), 32'h2);

    // 5 XOR 5 = 0
    drive_load(4'h5);
    chk("xor_reentry_valid", 32'(bus.result_valid), 32'h0);
    chk("xor_reentry_stage", 32'(bus.stage), 32'h2);
    drive_load(4'h5);
    load_op(5'h7, 2'b00);
    @(negedge clk);
    chk("xor_result", 32'(bus.result_q), 32'h0);
    chk("xor_z", 32'(bus.z_q), 32'h1);
    chk("xor_err", 32'(bus.err), 32'h0);
    chk("xor_count", 32'(bus.op_count), 32'h3);

    // Opcode out of range
    load_three(4'h1, 4'h1, 5'h0C, 2'b00);
    chk("badop_err", 32'(bus.err), 32'h1);
    chk("badop_valid", 32'(bus.result_valid), 32'h1);
    chk("badop_result", 32'(bus.result_q), 32'h0);
    chk("badop_count", 32'(bus.op_count), 32'h3);
    chk("badop_busy", 32'(bus.busy), 32'h0);
    chk("badop_ctrl", 32'(bus.alu_control), 32'h0C);

    // INC with flag 2 is invalid
    load_three(4'h2, 4'h2, 5'h3, 2'b10);
    chk("badflag_err", 32'(bus.err), 32'h1);
    chk("badflag_valid", 32'(bus.result_valid), 32'h1);
    chk("badflag_count", 32'(bus.op_count), 32'h3);

    // abort together with load in WAIT_OP
    drive_load(4'h7);
    drive_load(4'h6);
    @(negedge clk);
    bus.op_in = 5'h1;
    bus.flag_in = 2'b00;
    bus.load = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.abort = 1'b0;
    chk("abort_stage", 32'(bus.stage), 32'h1);
    chk("abort_ctrl", 32'(bus.alu_control), 32'h3);
    chk("abort_valid", 32'(bus.result_valid), 32'h0);
    chk("abort_err", 32'(bus.err), 32'h0);
    chk("abort_alu_a", 32'(bus.alu_a), 32'h7);
    chk("abort_count", 32'(bus.op_count), 32'h3);

    // reset in the middle of EXEC
    load_three(4'h2, 4'h3, 5'h2, 2'b00);
    chk("midexec_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_stage", 32'(bus.stage), 32'h1);
    chk("midrst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("midrst_ctrl", 32'(bus.alu_control), 32'h0);
    chk("midrst_count", 32'(bus.op_count), 32'h0);
    chk("midrst_result", 32'(bus.result_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 256 back-to-back adds, load held high during EXEC
    for (int i = 0; i < 256; i++) begin
      load_three(4'(i), 4'h1, 5'h2, 2'b00);
      bus.data_in = 4'hF;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      if (i == 0) begin
        chk("exec_load_alu_a", 32'(bus.alu_a), 32'h0);
        chk("exec_load_stage", 32'(bus.stage), 32'h0);
        chk("exec_load_result", 32'(bus.result_q), 32'h1);
      end
      if (i == 254) chk("count_255", 32'(bus.op_count), 32'hFF);
    end
    chk("count_wrap", 32'(bus.op_count), 32'h0);
    chk("last_result", 32'(bus.result_q), 32'h0);
    chk("last_c", 32'(bus.c_q), 32'h1);
    chk("last_z", 32'(bus.z_q), 32'h1);
    chk("last_valid", 32'(bus.result_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
